// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_engine
// Description : Computes one Conway B3/S23 generation per start request by
//               streaming the current board row by row from a synchronous
//               read port and writing the successor rows to the
//               next-generation buffer, then pulsing swap_out.
//               Board edges are dead (non-toroidal).
// Ports       : clk_in        - clock, rising edge
//               rst_in        - synchronous active-high reset
//               start_in      - request one generation step (ignored if busy)
//               logic_addr_r  - row address to the current-generation buffer
//               logic_data_r  - row data, valid one cycle after logic_addr_r
//               logic_addr_w  - row address to the next-generation buffer
//               logic_data_w  - successor row data
//               logic_wr_en   - write strobe, one row per asserted cycle
//               swap_out      - one-cycle pulse to swap the buffers
//               busy_out      - high while a step is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module life_engine #(
    parameter int ADDR_SIZE  = 32,
    parameter int LINE_WIDTH = 8,
    parameter int NUM_LINES  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic [ADDR_SIZE-1:0]  logic_addr_r,
    input  logic [LINE_WIDTH-1:0] logic_data_r,
    output logic [ADDR_SIZE-1:0]  logic_addr_w,
    output logic [LINE_WIDTH-1:0] logic_data_w,
    output logic                  logic_wr_en,
    output logic                  swap_out,
    output logic                  busy_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] SWAP  = 2'd3;

    localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(NUM_LINES - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  rd_vld;     // logic_data_r carries a board row this cycle
    logic                  calc_vld;   // window holds a complete neighbourhood
    logic [LINE_WIDTH-1:0] row_above;
    logic [LINE_WIDTH-1:0] row_cur;
    logic [LINE_WIDTH-1:0] row_below;
    logic [LINE_WIDTH-1:0] row_next;
    logic [ADDR_SIZE-1:0]  wr_cnt;
    logic                  last_write;

    // Zero-padded copies so the dead columns -1 and LINE_WIDTH fall out of
    // the same indexing as interior cells: column j sits at padded index j+1.
    logic [LINE_WIDTH+1:0] pad_above;
    logic [LINE_WIDTH+1:0] pad_cur;
    logic [LINE_WIDTH+1:0] pad_below;

    // Once the read stream has ended, the row below the last row is dead.
    assign row_below  = rd_vld ? logic_data_r : '0;
    assign pad_above  = {1'b0, row_above, 1'b0};
    assign pad_cur    = {1'b0, row_cur,   1'b0};
    assign pad_below  = {1'b0, row_below, 1'b0};
    assign last_write = logic_wr_en && (logic_addr_w == LAST_ROW);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in)                 state_nxt = READ;
            READ:    if (logic_addr_r == LAST_ROW) state_nxt = DRAIN;
            DRAIN:   if (last_write)               state_nxt = SWAP;
            SWAP:                                  state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        logic [3:0] cnt;
        cnt      = '0;
        row_next = '0;
        for (int j = 0; j < LINE_WIDTH; j++) begin
            cnt = 4'(pad_above[j]) + 4'(pad_above[j+1]) + 4'(pad_above[j+2])
                + 4'(pad_cur[j])                         + 4'(pad_cur[j+2])
                + 4'(pad_below[j]) + 4'(pad_below[j+1]) + 4'(pad_below[j+2]);
            row_next[j] = (cnt == 4'd3) || ((cnt == 4'd2) && pad_cur[j+1]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            logic_addr_r <= '0;
            logic_addr_w <= '0;
            logic_data_w <= '0;
            logic_wr_en  <= 1'b0;
            swap_out     <= 1'b0;
            busy_out     <= 1'b0;
            rd_vld       <= 1'b0;
            calc_vld     <= 1'b0;
            row_above    <= '0;
            row_cur      <= '0;
            wr_cnt       <= '0;
        end else begin
            state    <= state_nxt;
            busy_out <= (state_nxt != IDLE);
            swap_out <= (state == DRAIN) && last_write;
            rd_vld   <= (state == READ);
            calc_vld <= rd_vld;

            if ((state == IDLE) && start_in) begin
                logic_addr_r <= '0;
                row_above    <= '0;
                row_cur      <= '0;
                wr_cnt       <= '0;
            end else begin
                if ((state == READ) && (logic_addr_r != LAST_ROW)) begin
                    logic_addr_r <= logic_addr_r + ADDR_SIZE'(1);
                end
                // Shift while rows arrive and for one extra cycle so the last
                // row is evaluated against a dead row below it.
                if (rd_vld || calc_vld) begin
                    row_above <= row_cur;
                    row_cur   <= row_below;
                end
            end

            logic_wr_en <= calc_vld;
            if (calc_vld) begin
                logic_addr_w <= wr_cnt;
                logic_data_w <= row_next;
                wr_cnt       <= wr_cnt + ADDR_SIZE'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_engine
// Description : Self-checking bench for life_engine. The stimulus process
//               loads boards, issues steps and pushes expected writes and
//               swap pulses (from a cell-by-cell Life model) into queues;
//               a negedge monitor pops and compares whatever the DUT emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_engine;

    localparam int AW = 32;
    localparam int LW = 8;
    localparam int NL = 8;

    typedef logic [LW-1:0] row_t;
    typedef struct {
        int   cyc;
        int   addr;
        row_t data;
    } wr_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] logic_addr_r;
    logic [LW-1:0] logic_data_r;
    logic [AW-1:0] logic_addr_w;
    logic [LW-1:0] logic_data_w;
    logic          logic_wr_en;
    logic          swap_out;
    logic          busy_out;

    life_engine #(.ADDR_SIZE(AW), .LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .logic_addr_r (logic_addr_r),
        .logic_data_r (logic_data_r),
        .logic_addr_w (logic_addr_w),
        .logic_data_w (logic_data_w),
        .logic_wr_en  (logic_wr_en),
        .swap_out     (swap_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    row_t cur_mem [NL];
    row_t pend_gen [NL];
    int   pend_swap = -1;
    int   busy_lo = 1, busy_hi = 0;
    int   rd_lo = 1, rd_hi = 0, rd_s = 0;
    wr_t  wq[$];
    int   sq[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Current-generation buffer: synchronous read, one cycle latency.
    always @(posedge clk_in) begin
        if (logic_addr_r < AW'(NL)) logic_data_r <= cur_mem[logic_addr_r];
        else                         logic_data_r <= '0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic row_t life_row(input int i);
        row_t r;
        int   n;
        r = '0;
        for (int j = 0; j < LW; j++) begin
            n = 0;
            for (int di = -1; di <= 1; di++)
                for (int dj = -1; dj <= 1; dj++)
                    if (!(di == 0 && dj == 0) && (i + di) >= 0 && (i + di) < NL
                        && (j + dj) >= 0 && (j + dj) < LW && cur_mem[i + di][j + dj])
                        n++;
            r[j] = (n == 3) || (n == 2 && cur_mem[i][j]);
        end
        return r;
    endfunction

    // Record everything a step launched with start sampled in cycle s must do.
    task automatic push_expect(input int s);
        for (int i = 0; i < NL; i++) begin
            pend_gen[i] = life_row(i);
            wq.push_back('{cyc: s + 4 + i, addr: i, data: pend_gen[i]});
        end
        sq.push_back(s + 4 + NL);
        pend_swap = s + 4 + NL;
        busy_lo = s + 1;
        busy_hi = s + 4 + NL;
        rd_s  = s;
        rd_lo = s + 1;
        rd_hi = s + NL;
    endtask

    // Reset sampled at the end of cycle r: nothing may happen from r+1 on.
    task automatic abort_expect(input int r);
        while (wq.size() > 0 && wq[$].cyc > r) void'(wq.pop_back());
        while (sq.size() > 0 && sq[$] > r) void'(sq.pop_back());
        if (busy_hi > r) busy_hi = r;
        if (rd_hi > r) rd_hi = r;
        if (pend_swap > r) pend_swap = -1;
    endtask

    always @(negedge clk_in) begin
        if (mon_en) begin
            wr_t e;
            chk("busy_out", 64'(busy_out), 64'(cyc >= busy_lo && cyc <= busy_hi));
            if (cyc >= rd_lo && cyc <= rd_hi)
                chk("logic_addr_r", 64'(logic_addr_r), 64'(cyc - rd_s - 1));
            if (logic_wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = wq.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                    chk("logic_addr_w", 64'(logic_addr_w), 64'(e.addr));
                    chk("logic_data_w", 64'(logic_data_w), 64'(e.data));
                end
            end else begin
                chk("logic_wr_en_x", 64'(logic_wr_en), 64'd0);
                if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                    e = wq.pop_front();
                    chk("missing_write_row", 64'(e.addr + 1000), 64'(e.addr));
                end
            end
            if (swap_out === 1'b1) begin
                if (sq.size() == 0) chk("unexpected_swap", 64'd1, 64'd0);
                else                chk("swap_cycle", 64'(cyc), 64'(sq.pop_front()));
            end else begin
                chk("swap_out_x", 64'(swap_out), 64'd0);
                if (sq.size() > 0 && sq[0] <= cyc)
                    chk("missing_swap", 64'(cyc), 64'(sq.pop_front()));
            end
            if (cyc == pend_swap) cur_mem = pend_gen;
        end
    end

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    task automatic load(input row_t r0, input row_t r1, input row_t r2,
                        input row_t r3, input row_t r4);
        for (int i = 0; i < NL; i++) cur_mem[i] = '0;
        cur_mem[0] = r0; cur_mem[1] = r1; cur_mem[2] = r2;
        cur_mem[3] = r3; cur_mem[4] = r4;
    endtask

    // Issues one start pulse in a cycle where the DUT should be idle; returns S.
    task automatic start_step(input bit keep, output int s);
        @(negedge clk_in);
        s = cyc;
        push_expect(s);
        start_in = 1'b1;
        @(negedge clk_in);
        if (!keep) start_in = 1'b0;
    endtask

    initial begin
        int s;
        for (int i = 0; i < NL; i++) cur_mem[i] = '0;
        rst_in   = 1'b1;
        start_in = 1'b1;            // must be ignored while in reset
        @(posedge clk_in);
        @(negedge clk_in);
        mon_en = 1'b1;
        repeat (3) begin
            chk("rst_addr_r", 64'(logic_addr_r), 64'd0);
            chk("rst_addr_w", 64'(logic_addr_w), 64'd0);
            chk("rst_data_w", 64'(logic_data_w), 64'd0);
            @(negedge clk_in);
        end
        start_in = 1'b0;
        rst_in   = 1'b0;
        repeat (3) @(negedge clk_in);

        // Blinker
        load(8'h00, 8'h00, 8'h08, 8'h08, 8'h08);
        start_step(1'b0, s);
        wait_cycle(busy_hi + 3);
        // Block still life
        load(8'h00, 8'h06, 8'h06, 8'h00, 8'h00);
        start_step(1'b0, s);
        wait_cycle(busy_hi + 2);
        // Edge cells die without wrap-around
        load(8'h81, 8'h81, 8'h00, 8'h00, 8'h00);
        start_step(1'b0, s);
        wait_cycle(busy_hi + 2);

        // Start pulse during a step is ignored
        for (int i = 0; i < NL; i++) cur_mem[i] = row_t'($urandom_range(0, 255));
        start_step(1'b0, s);
        wait_cycle(s + 5);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_cycle(busy_hi + 4);

        // Reset mid-step aborts it; a following step runs normally
        for (int i = 0; i < NL; i++) cur_mem[i] = row_t'($urandom_range(0, 255));
        start_step(1'b0, s);
        wait_cycle(s + 7);
        abort_expect(s + 7);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("abort_addr_r", 64'(logic_addr_r), 64'd0);
        chk("abort_addr_w", 64'(logic_addr_w), 64'd0);
        chk("abort_data_w", 64'(logic_data_w), 64'd0);
        repeat (12) @(negedge clk_in);
        start_step(1'b0, s);
        wait_cycle(busy_hi + 2);

        // start held high: three back-to-back steps, period NL+5
        for (int i = 0; i < NL; i++) cur_mem[i] = row_t'($urandom_range(0, 255));
        start_step(1'b1, s);
        for (int k = 1; k < 3; k++) begin
            wait_cycle(s + k * (NL + 5));
            push_expect(s + k * (NL + 5));
        end
        @(negedge clk_in);
        start_in = 1'b0;
        wait_cycle(busy_hi + 3);

        // Random boards
        repeat (6) begin
            for (int i = 0; i < NL; i++) cur_mem[i] = row_t'($urandom_range(0, 255));
            start_step(1'b0, s);
            wait_cycle(busy_hi + 1 + int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk_in);
        chk("write_queue_empty", 64'(wq.size()), 64'd0);
        chk("swap_queue_empty", 64'(sq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 Parameter ADDR_SIZE, default 32: width of the row-address ports.
REQ-002 Parameter LINE_WIDTH, default 8: cells per row; one address holds one row.
REQ-003 Parameter NUM_LINES, default 8: rows in the board, 2..2^ADDR_SIZE.
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous and active-high.
REQ-006 start_in  input  1  request one generation step; sampled each cycle.
REQ-007 logic_addr_r  output  ADDR_SIZE  row address read from the current-generation buffer.
REQ-008 logic_data_r  input  LINE_WIDTH  row data; valid exactly one cycle after logic_addr_r is presented.
REQ-009 logic_addr_w  output  ADDR_SIZE  row address written to the next-generation buffer.
REQ-010 logic_data_w  output  LINE_WIDTH  next-generation row data.
REQ-011 logic_wr_en  output  1  write strobe, one row per asserted cycle.
REQ-012 swap_out  output  1  one-cycle pulse that swaps the buffers.
REQ-013 busy_out  output  1  high while a generation step is in progress.

Function
REQ-014 States SHALL be IDLE, READ, DRAIN and SWAP.
- IDLE -> READ when start_in=1.
- READ -> DRAIN after address NUM_LINES-1 is issued.
- DRAIN -> SWAP after the last row is written.
- SWAP -> IDLE after one cycle.
REQ-015 Let S be the cycle in which start_in=1 is sampled in IDLE.
- In cycle S+1+i, for i = 0..NUM_LINES-1, logic_addr_r SHALL equal i.
- Reads are consecutive; no address is repeated or skipped.
REQ-016 The block SHALL keep a three-row window (above, current, below) filled from logic_data_r.
REQ-017 Write timing: for each row i, logic_wr_en=1 and logic_addr_w=i in cycle S+4+i, all outputs registered; writes are consecutive for i = 0..NUM_LINES-1.
REQ-018 logic_data_w bit j of row i SHALL be the Conway B3/S23 successor of cell (i,j):
- alive next iff live neighbours = 3, or live neighbours = 2 and the cell is alive.
- The neighbour count is a 4-bit sum over the 8 neighbours.
REQ-019 Board edges are not toroidal: row -1, row NUM_LINES, column -1 and column LINE_WIDTH are dead.
REQ-020 Bit j of a row is column j; bit 0 is the left edge.
REQ-021 swap_out SHALL pulse high for exactly one cycle, S+4+NUM_LINES, strictly after the last write.
REQ-022 busy_out SHALL be high from S+1 through S+4+NUM_LINES inclusive, and low otherwise.
REQ-023 start_in asserted while busy_out=1 or during the SWAP cycle SHALL be ignored; it is neither queued nor able to restart the sweep.
REQ-024 start_in held high continuously SHALL launch a new step in the first IDLE cycle after SWAP, so steps run back-to-back with period NUM_LINES+5.
REQ-025 logic_wr_en SHALL be 0 in every cycle outside S+4 .. S+3+NUM_LINES.
- logic_addr_w and logic_data_w are don't-care while logic_wr_en=0.
REQ-026 The row counter SHALL be ADDR_SIZE wide and SHALL never wrap past NUM_LINES-1 within one step.

Reset
REQ-027 While rst_in=1 the block SHALL enter IDLE and clear the window registers and counters, with outputs:
- logic_addr_r=0, logic_addr_w=0, logic_data_w=0
- logic_wr_en=0, swap_out=0, busy_out=0
REQ-028 Reset asserted mid-step SHALL abort the step in the next cycle: no further writes and no swap_out pulse.
REQ-029 After rst_in deasserts, the block SHALL wait in IDLE for start_in.
REQ-030 start_in coincident with rst_in=1 SHALL be ignored.

Verification
REQ-031 Blinker, LINE_WIDTH=8, NUM_LINES=8: rows 2,3,4 = 8'h08, one start pulse.
- Expect row 3 written 8'h1C and all other rows 8'h00.
- Writes occur in cycles S+4..S+11; swap_out at S+12.
REQ-032 Block still life: rows 1 and 2 = 8'h06.
- Expect rows 1 and 2 written 8'h06 and all other rows 0.
- busy_out high for exactly 12 cycles.
REQ-033 Edge cells: row 0 = 8'h81 and row 1 = 8'h81.
- Expect every row written 0, because each live cell has only one live neighbour.
- A toroidal implementation would produce a different result, so this scenario distinguishes the two.
REQ-034 start_in pulsed at S+5 during a step.
- Expect no change to the write or read sequence and exactly one swap_out.
- Expect IDLE after S+12 with no second step.
REQ-035 rst_in asserted at S+7 for one cycle.
- Expect logic_wr_en=0 from S+8 onward, no swap_out and busy_out=0.
- A start_in after reset runs a full, correct step.
REQ-036 start_in held high over 3 steps.
- Expect swap_out pulses exactly 13 cycles apart.
- Each step's logic_addr_r sequence restarts at 0.
